// File: rtl/reg_file_rename_if.sv
// ID/ROB-facing port bundle of the rename-aware register file.
// Register indices are 5 bits and data is 32 bits wide.
interface reg_file_rename_if #(
    parameter int unsigned RSID_WIDTH = 4
) ();
    // ID source reads
    logic                  read_en_1;
    logic [4:0]            read_addr_1;
    logic                  read_is_rsid_1;
    logic [31:0]           read_data_1;
    logic                  read_en_2;
    logic [4:0]            read_addr_2;
    logic                  read_is_rsid_2;
    logic [31:0]           read_data_2;
    // ID destination rename
    logic                  rename_en;
    logic [4:0]            rename_addr;
    logic [RSID_WIDTH-1:0] rename_rsid;
    // ROB commit
    logic                  commit_en;
    logic [4:0]            commit_addr;
    logic [RSID_WIDTH-1:0] commit_rsid;
    logic [31:0]           commit_data;

    // Driven by the ID stage and the ROB
    modport master (
        output read_en_1, read_addr_1, read_en_2, read_addr_2,
        output rename_en, rename_addr, rename_rsid,
        output commit_en, commit_addr, commit_rsid, commit_data,
        input  read_is_rsid_1, read_data_1, read_is_rsid_2, read_data_2
    );

    // Driven by the register file
    modport slave (
        input  read_en_1, read_addr_1, read_en_2, read_addr_2,
        input  rename_en, rename_addr, rename_rsid,
        input  commit_en, commit_addr, commit_rsid, commit_data,
        output read_is_rsid_1, read_data_1, read_is_rsid_2, read_data_2
    );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename (busy/tag) status.
// Two combinational read ports return either a value or the producing tag,
// with a same-cycle bypass from a matching ROB commit. RSID_WIDTH must be <= 32.
module reg_file_rename #(
    parameter int unsigned RSID_WIDTH = 4,
    parameter int unsigned REG_COUNT  = 32
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    reg_file_rename_if.slave bus
);

    logic [31:0]           value_q [REG_COUNT];
    logic [31:0]           value_d [REG_COUNT];
    logic [RSID_WIDTH-1:0] tag_q   [REG_COUNT];
    logic [RSID_WIDTH-1:0] tag_d   [REG_COUNT];
    logic [REG_COUNT-1:0]  busy_q;
    logic [REG_COUNT-1:0]  busy_d;

    logic        rd_en      [2];
    logic [4:0]  rd_addr    [2];
    logic        rd_is_rsid [2];
    logic [31:0] rd_data    [2];

    assign rd_en[0]   = bus.read_en_1;
    assign rd_addr[0] = bus.read_addr_1;
    assign rd_en[1]   = bus.read_en_2;
    assign rd_addr[1] = bus.read_addr_2;

    assign bus.read_is_rsid_1 = rd_is_rsid[0];
    assign bus.read_data_1    = rd_data[0];
    assign bus.read_is_rsid_2 = rd_is_rsid[1];
    assign bus.read_data_2    = rd_data[1];

    // Read ports: old state only (same-cycle renames are invisible), with commit bypass
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_is_rsid[p] = 1'b0;
            rd_data[p]    = '0;
            if (rst && rd_en[p] && rd_addr[p] != 5'd0 && 32'(rd_addr[p]) < REG_COUNT) begin
                if (bus.commit_en && bus.commit_addr == rd_addr[p] &&
                    busy_q[rd_addr[p]] && tag_q[rd_addr[p]] == bus.commit_rsid) begin
                    rd_data[p] = bus.commit_data;
                end else if (busy_q[rd_addr[p]]) begin
                    rd_is_rsid[p]               = 1'b1;
                    rd_data[p][RSID_WIDTH-1:0]  = tag_q[rd_addr[p]];
                end else begin
                    rd_data[p] = value_q[rd_addr[p]];
                end
            end
        end
    end

    // Next state: commit writes value; busy/tag priority is flush > rename > commit
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        // Register 0 is skipped so it stays zero and never busy
        for (int i = 1; i < REG_COUNT; i++) begin
            if (bus.commit_en && bus.commit_addr == 5'(i)) begin
                value_d[i] = bus.commit_data;
                // A stale commit (register renamed again since) leaves busy set
                if (tag_q[i] == bus.commit_rsid) begin
                    busy_d[i] = 1'b0;
                end
            end
            if (bus.rename_en && bus.rename_addr == 5'(i) && !flush) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = bus.rename_rsid;
            end
            if (flush) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q <= '{default: '0};
            tag_q   <= '{default: '0};
            busy_q  <= '0;
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register rename status.
- Responder side of the ID-stage regfile reader/writer interface:
  - answers ID's two source reads with either a value or the producing RS/ROB id;
  - accepts destination renames from ID;
  - retires results written back by the ROB.
- Sits between ID (reads/renames) and ROB commit (writes); flushed on misprediction.

Parameters:
- RSID_WIDTH, 4, width of the RS/ROB tag returned for renamed registers (must be ≤ 32).
- REG_COUNT, 32, number of architectural registers; addressed by `REG_ADDR_BUS` (5 bits).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-low reset
- flush  in  1  discard all pending renames
- read_en_1  in  1  read port 1 enable
- read_addr_1  in  `REG_ADDR_BUS`  read port 1 register index
- read_is_rsid_1  out  1  port 1 result is a tag, not a value
- read_data_1  out  `DATA_BUS`  port 1 value, or zero-extended tag
- read_en_2 / read_addr_2 / read_is_rsid_2 / read_data_2  same as port 1, for port 2
- rename_en  in  1  ID marks a destination register pending
- rename_addr  in  `REG_ADDR_BUS`  destination register
- rename_rsid  in  RSID_WIDTH  tag of the producing RS/ROB entry
- commit_en  in  1  ROB retires a result
- commit_addr  in  `REG_ADDR_BUS`  retired destination register
- commit_rsid  in  RSID_WIDTH  tag of the retiring entry
- commit_data  in  `DATA_BUS`  retired value

Behaviour:
- State per register: value[31:0], busy, tag[RSID_WIDTH-1:0].
- Reset (rst low at a clock edge):
  - every value = 0, busy = 0, tag = 0.
  - While rst is low, both read ports output read_is_rsid = 0 and read_data = 0.
- Reads are combinational, zero latency. For each port:
  - Port disabled: is_rsid = 0, data = 0.
  - addr = 0: is_rsid = 0, data = 0.
  - commit_en && commit_addr == addr && busy[addr] && tag[addr] == commit_rsid: bypass, is_rsid = 0, data = commit_data.
  - Otherwise busy[addr] = 1: is_rsid = 1, data = {zeros, tag[addr]}.
  - Otherwise: is_rsid = 0, data = value[addr].
  - A rename in the same cycle never affects that cycle's reads. An instruction reading and renaming the same register sees the old state.
- Commit (commit_en, commit_addr != 0), at the clock edge:
  - value[commit_addr] = commit_data, always.
  - busy cleared only if tag[commit_addr] == commit_rsid. A stale commit (register since renamed to a younger tag) keeps busy/tag unchanged.
- Rename (rename_en, rename_addr != 0), at the clock edge: busy = 1, tag = rename_rsid. Re-renaming a busy register overwrites the tag.
- Simultaneous commit and rename, same register: value takes commit_data; busy = 1, tag = rename_rsid (rename wins).
- Register 0: writes, commits and renames are ignored. Never busy, always reads 0.
- flush, at the clock edge:
  - all busy cleared; values and tags unchanged.
  - A commit in the same cycle still writes its value.
  - A rename in the same cycle is discarded.
- Priority per cycle: rst > flush > rename > commit (for busy/tag); commit value write is independent.
- No backpressure: all ports are accepted every cycle.

Test Plan:
- Reset, then read r5 on both ports -> is_rsid = 0, data = 0; read_en low -> outputs 0.
- Commit r3 = 0xDEADBEEF (not busy) -> next cycle, read r3 gives is_rsid = 0, data = 0xDEADBEEF.
- Rename r7 with tag 5; next cycle read r7 -> is_rsid = 1, data = 0x5.
  - Then commit r7 tag 5 data 0x1234: same-cycle read gives is_rsid = 0, data = 0x1234 (bypass).
  - Following cycle: not busy, value 0x1234.
- Rename r7 tag 2, then r7 tag 9, then commit r7 tag 2 data 0xAA -> value = 0xAA, read still returns is_rsid = 1, data = 0x9. Commit r7 tag 9 -> busy cleared.
- Same cycle: rename r4 tag 3 and read r4 (previous value 0x10, not busy) -> read returns 0x10, is_rsid = 0. Next cycle: is_rsid = 1, data = 0x3.
- Rename r1 (tag 1) and r2 (tag 2), then flush together with rename r6 tag 4 -> r1, r2, r6 all read not-busy with old values. Rename r0 tag 7 -> r0 reads 0, not busy.
